// File: rtl/ram_lanes.sv
// Byte-lane data RAM: one array per lane, registered read with
// sign/zero extension and a post-reset clear sequencer.
module ram_lanes #(
  parameter int ADDR_LENGTH    = 21,
  parameter int LANES          = 4,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int W             = 8 * LANES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_we_i,
  input  logic [1:0]   req_size_i,
  input  logic         req_unsigned_i,
  input  logic [31:0]  req_addr_i,
  input  logic [W-1:0] req_wdata_i,
  output logic         rsp_valid_o,
  output logic [W-1:0] rsp_data_o,
  output logic         busy_o
);

  localparam int OFFB  = $clog2(LANES);
  localparam int IDXW  = ADDR_LENGTH - OFFB;
  localparam int WORDS = 1 << IDXW;
  localparam logic [IDXW-1:0] LAST = '1;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] clr_q, clr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == S_CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == LAST) state_d = S_READY;
    end
  end

  always_comb begin
    req_ready_o = (state_q == S_READY);
    busy_o      = (state_q == S_CLEAR);
  end

  logic            unused_addr;
  logic [OFFB-1:0] off, kk;
  logic [IDXW-1:0] word;
  logic [1:0]      sz;
  logic            acc, ld_acc, st_we, clr_we;
  logic [IDXW-1:0] idx [LANES];
  logic [7:0]      wbyte [LANES];
  logic [LANES-1:0] wen;

  assign unused_addr = ^req_addr_i[31:ADDR_LENGTH];
  assign off    = req_addr_i[OFFB-1:0];
  assign word   = req_addr_i[ADDR_LENGTH-1:OFFB];
  assign sz     = (req_size_i > 2'(OFFB)) ? 2'(OFFB) : req_size_i;
  assign acc    = req_valid_i && req_ready_o;
  assign ld_acc = acc && !req_we_i;
  assign st_we  = acc && req_we_i;
  assign clr_we = (state_q == S_CLEAR);

  // Lanes below the offset hold the bytes that spill into word+1
  always_comb begin
    kk = '0;
    for (int l = 0; l < LANES; l++) begin
      kk       = OFFB'(l) - off;
      idx[l]   = word + {{(IDXW-1){1'b0}}, (OFFB'(l) < off)};
      wen[l]   = 32'(kk) < (32'd1 << sz);
      wbyte[l] = req_wdata_i[8*kk +: 8];
    end
  end

  logic [W-1:0] lane_w;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (clr_we) mem[clr_q] <= '0;
      else if (st_we && wen[l]) mem[idx[l]] <= wbyte[l];
      if (ld_acc) lane_q <= mem[idx[l]];
    end

    assign lane_w[8*l +: 8] = lane_q;
  end

  logic            ld_q, uns_q, rsp_valid_q;
  logic [OFFB-1:0] off_q, src;
  logic [1:0]      sz_q;
  logic [W-1:0]    res, rsp_data_q;
  logic            fill;

  always_comb begin
    res  = '0;
    fill = 1'b0;
    src  = '0;
    for (int k = 0; k < LANES; k++) begin
      src = OFFB'(k) + off_q;
      if (k < (1 << sz_q)) begin
        res[8*k +: 8] = lane_w[8*src +: 8];
        fill          = lane_w[8*src + 7] & ~uns_q;
      end
    end
    for (int k = 0; k < LANES; k++)
      if (k >= (1 << sz_q)) res[8*k +: 8] = {8{fill}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q        <= 1'b0;
      off_q       <= '0;
      sz_q        <= '0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ld_q <= ld_acc;
      if (ld_acc) begin
        off_q <= off;
        sz_q  <= sz;
        uns_q <= req_unsigned_i;
      end
      rsp_valid_q <= ld_q;
      if (ld_q) rsp_data_q <= res;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_ram_lanes.sv
// Bench for ram_lanes: flat byte-array reference model plus
// directed plan cases and randomized traffic.
module tb_ram_lanes;

  localparam int AL    = 6;
  localparam int LN    = 4;
  localparam int BYTES = 1 << AL;
  localparam int WORDS = BYTES / LN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  ram_lanes #(
    .ADDR_LENGTH(AL),
    .LANES(LN),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i(req_we),
    .req_size_i(req_size),
    .req_unsigned_i(req_uns),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: flat byte memory, address wraps modulo capacity
  logic [7:0]  mem [BYTES];
  logic        m_busy = 1'b1;
  int          m_cnt = 0;
  logic        exp_v = 1'b0;
  logic        exp_ld = 1'b0;
  logic [31:0] exp_d = '0;
  logic [31:0] exp_nd = '0;
  logic        chk_on = 1'b0;

  function automatic int nbytes(input logic [1:0] s);
    return (s > 2) ? 4 : (1 << s);
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a,
                                        input logic [1:0] s,
                                        input logic u);
    logic [31:0] r = '0;
    int n = nbytes(s);
    for (int k = 0; k < n; k++) r[8*k +: 8] = mem[(a + k) % BYTES];
    if (!u && r[8*n-1])
      for (int k = n; k < 4; k++) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d);
    for (int k = 0; k < nbytes(s); k++) mem[(a + k) % BYTES] = d[8*k +: 8];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      exp_v  = 1'b0;
      exp_ld = 1'b0;
      exp_d  = '0;
    end else begin
      exp_v = exp_ld;
      if (exp_ld) exp_d = exp_nd;
      exp_ld = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == WORDS) begin
          m_busy = 1'b0;
          for (int i = 0; i < BYTES; i++) mem[i] = 8'h00;
        end
      end else if (req_valid) begin
        if (req_we) mstore(req_addr, req_size, req_wdata);
        else begin
          exp_ld = 1'b1;
          exp_nd = mload(req_addr, req_size, req_uns);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("rsp_data", rsp_data, exp_d);
    end
  end

  task automatic cyc(input logic v, input logic we, input logic [1:0] s,
                     input logic u, input logic [31:0] a,
                     input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_size  = s;
    req_uns   = u;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] s,
                    input logic [31:0] d);
    cyc(1'b1, 1'b1, s, 1'b0, a, d);
  endtask

  task automatic ld_exp(input string tag, input logic [31:0] a,
                        input logic [1:0] s, input logic u,
                        input logic [31:0] exp);
    cyc(1'b1, 1'b0, s, u, a, 32'h0);
    idle();
    chk({tag, "_v"}, 32'(rsp_valid), 32'd1);
    chk(tag, rsp_data, exp);
  endtask

  task automatic clear_len(input string tag);
    int n = 0;
    for (int i = 0; i < 4 * WORDS; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(WORDS));
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);

    // Reset during the clear must restart it from word 0
    rst = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_len("clear_len");
    ld_exp("clr_word", 32'h3C, 2'd2, 1'b0, 32'h0);

    st(32'h0E, 2'd2, 32'hAABBCCDD);
    ld_exp("straddle_lo", 32'h0C, 2'd2, 1'b0, 32'hCCDD0000);
    ld_exp("straddle_hi", 32'h10, 2'd2, 1'b0, 32'h0000AABB);
    st(32'h3F, 2'd1, 32'h0000BEEF);
    ld_exp("wrap_half", 32'h3F, 2'd1, 1'b1, 32'h0000BEEF);
    ld_exp("wrap_byte0", 32'h00, 2'd0, 1'b1, 32'h000000BE);

    st(32'h10, 2'd2, 32'h12345678);
    ld_exp("word", 32'h10, 2'd2, 1'b0, 32'h12345678);
    ld_exp("byte13", 32'h13, 2'd0, 1'b0, 32'h00000012);
    ld_exp("half12", 32'h12, 2'd1, 1'b0, 32'h00001234);

    st(32'h21, 2'd0, 32'h00000080);
    ld_exp("sbyte", 32'h21, 2'd0, 1'b0, 32'hFFFFFF80);
    ld_exp("ubyte", 32'h21, 2'd0, 1'b1, 32'h00000080);
    ld_exp("lanes20", 32'h20, 2'd2, 1'b0, 32'h00008000);
    ld_exp("illegal_sz", 32'h21, 2'd3, 1'b0, 32'h00000080);

    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10 + 32'(4 * i), 32'h0);
    idle();
    idle();
    st(32'h18, 2'd2, 32'hCAFEF00D);
    ld_exp("raw", 32'h18, 2'd2, 1'b0, 32'hCAFEF00D);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle();
      else cyc(1'b1, 1'($urandom), 2'($urandom), 1'($urandom),
               $urandom, $urandom);
    end
    idle();

    st(32'h24, 2'd2, 32'h5A5A5A5A);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_len("reclear_len");
    ld_exp("after_clear", 32'h24, 2'd2, 1'b0, 32'h0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
